// File: rtl/sync_fifo_if.sv
// Producer/consumer ready-valid bundle for sync_fifo.
// The FIFO takes the slave side; whoever feeds and drains it takes the master side.
interface sync_fifo_if #(
  parameter int unsigned DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/sync_fifo.sv
// Parametrised first-word-fall-through FIFO with occupancy status, flush,
// blocking or dropping overflow behaviour and sticky overflow/underflow flags.
module sync_fifo #(
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned DEPTH         = 1024,
  parameter int unsigned AFULL_THRESH  = DEPTH - 4,
  parameter int unsigned AEMPTY_THRESH = 4,
  parameter bit          BLOCKING      = 1'b1,
  localparam int unsigned PTR_W        = $clog2(DEPTH),
  localparam int unsigned LVL_W        = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             clr_err,
  sync_fifo_if.slave       bus,
  output logic [LVL_W-1:0] level,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [LVL_W-1:0] LvlFull = LVL_W'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic full, empty;
  logic push, pop;
  logic ovf_evt, udf_evt;

  // Status decode from registered level only; handshake inputs never reach in_ready/out_valid.
  always_comb begin
    full    = (level_q == LvlFull);
    empty   = (level_q == '0);
    push    = bus.in_valid & ~full;
    pop     = bus.out_ready & ~empty;
    ovf_evt = bus.in_valid & full;
    udf_evt = bus.out_ready & empty;
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    level_d = level_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      level_d = '0;
    end else begin
      if (push) tail_d = tail_q + 1'b1;
      if (pop)  head_d = head_q + 1'b1;
      case ({push, pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
    // Error events use the pre-flush level and win over a same-cycle clear.
    overflow_d  = ovf_evt | (overflow_q & ~clr_err);
    underflow_d = udf_evt | (underflow_q & ~clr_err);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage carries no reset so it can map onto plain flops or RAM.
  always_ff @(posedge clk) begin
    if (!rst && !flush && push) begin
      mem_q[tail_q] <= bus.in_data;
    end
  end

  always_comb begin
    bus.in_ready  = BLOCKING ? ~full : 1'b1;
    bus.out_valid = ~empty;
    bus.out_data  = mem_q[head_q];
    level         = level_q;
    almost_full   = (32'(level_q) >= AFULL_THRESH);
    almost_empty  = (32'(level_q) <= AEMPTY_THRESH);
    overflow      = overflow_q;
    underflow     = underflow_q;
  end

  // Pointer distance must always agree with the separately kept level counter.
  a_level_bound : assert property (@(posedge clk) disable iff (rst) level_q <= LvlFull);
  a_ptr_level   : assert property (@(posedge clk) disable iff (rst)
                                   PTR_W'(tail_q - head_q) == level_q[PTR_W-1:0]);

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Parametrised synchronous FIFO that replaces the fixed 8-bit × 1024 byte queue. It is used wherever the design buffers event or byte streams between producer and consumer stages. It has configurable width and depth, ready/valid handshakes on both sides, and first-word-fall-through output. It also provides level and almost-full/almost-empty status, a flush, and a selectable blocking or dropping overflow mode with sticky error flags.

## Interface
Parameters:
- DATA_W, 8, data word width in bits (≥1)
- DEPTH, 1024, number of entries; power of two, ≥2
- AFULL_THRESH, DEPTH-4, almost_full asserts when level ≥ this
- AEMPTY_THRESH, 4, almost_empty asserts when level ≤ this
- BLOCKING, 1, 1 = backpressure via in_ready; 0 = in_ready tied high, writes while full are dropped

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  synchronous clear of contents (pointers, level); error flags untouched
- in_valid  in  1  producer has a word
- in_data  in  DATA_W  producer word
- in_ready  out  1  FIFO can accept; BLOCKING=1: level≠DEPTH; BLOCKING=0: constant 1
- out_valid  out  1  level≠0
- out_data  out  DATA_W  word at head (FWFT); don't-care when out_valid=0
- out_ready  in  1  consumer takes the head word
- level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- almost_full  out  1  level ≥ AFULL_THRESH
- almost_empty  out  1  level ≤ AEMPTY_THRESH
- overflow  out  1  sticky: a write was attempted while full
- underflow  out  1  sticky: out_ready was asserted while empty
- clr_err  in  1  clears overflow/underflow

## Operation
- Storage: DEPTH × DATA_W flop array, not reset. Head and tail pointers are $clog2(DEPTH) bits and wrap naturally (DEPTH-1 → 0). level is a separate registered counter.
- Push: in_valid & level≠DEPTH. Writes mem[tail], tail+1.
- Pop: out_ready & level≠0. head+1.
- level update: push only +1; pop only -1; both or neither unchanged.
- Simultaneous push and pop are legal at any nonzero level below DEPTH. At level=DEPTH no push occurs, even if a pop occurs the same cycle (no pass-through). At level=0 no pop occurs and the pushed word lands.
- out_data = mem[head], combinational read of the array; no output register.
- Overflow: in_valid & level==DEPTH sets overflow. In BLOCKING=1 this is the normal stall condition, but the flag is still set. In BLOCKING=0 the word is dropped.
- Underflow: out_ready & level==0 sets underflow. State is otherwise unchanged.
- clr_err clears both flags. A new error event in the same cycle wins (flag stays 1).
- flush: head=tail=0, level=0; a push or pop in the same cycle is ignored. Error events are still evaluated that cycle against the pre-flush level.
- Priority: rst > flush > push/pop.
- Reset values: level=0, out_valid=0, in_ready=1, almost_full=0 (AFULL_THRESH≥1), almost_empty=1, overflow=0, underflow=0. Pointers are 0. out_data is don't-care.

## Timing
- A word accepted at edge N is visible at the head when out_valid rises after edge N if the FIFO was empty. Push-to-out_valid latency is 1 cycle.
- A pop at edge N presents the next word on out_data immediately after edge N, with 0 added latency.
- in_ready, out_valid, almost_* and level are functions of registered state only. They update on the edge following the causing event, and none depends combinationally on in_valid or out_ready.
- Error flags assert on the edge after the offending cycle and stay high until clr_err or rst.
- Sustained throughput is 1 push and 1 pop per cycle at any level 1..DEPTH-1.

## Test plan
- Reset, then fill: DEPTH=8, DATA_W=8. Push 0x01..0x08 back-to-back.
  - Required: level counts 1..8; in_ready=0 after the 8th push; almost_full set from level 4 (AFULL_THRESH=4).
  - Required: a 9th in_valid sets overflow and leaves level=8.
- Drain: from the full state, hold out_ready=1 for 9 cycles.
  - Required: out_data 0x01..0x08 in order; out_valid=0 after 8 pops.
  - Required: the 9th cycle sets underflow, and level stays 0.
- Wrap and concurrency: push 12 words while popping from cycle 3 onward, with in_valid and out_ready both held high.
  - Required: level holds steady during overlap; the output sequence is exact through pointer wrap.
  - Required: at level=8 with pop and push asserted, level goes to 7 and the pushed word is not stored.
- BLOCKING=0: fill to 8, then push 0xAA.
  - Required: in_ready stays 1 and 0xAA never appears at the output; overflow=1.
  - Required: clr_err asserted with a concurrent write-while-full leaves overflow=1; clr_err alone clears it.
- Flush: at level=5, assert flush together with push and pop.
  - Required: next cycle level=0, out_valid=0, error flags unchanged.
  - Required: a subsequent push of 0x5C appears at out_data one cycle later.
- Reset mid-operation: assert rst at level=3 with overflow=1.
  - Required: next cycle level=0, out_valid=0, in_ready=1, overflow=0, underflow=0, almost_empty=1.
